freq_div_multi: RTL

//   N-channel programmable clock divider; each channel outputs a 50% square wave and a one-cycle tick.

---
 rtl/freq_div_multi.sv | 108 ++++++++++
 1 files changed

// File: rtl/freq_div_multi.sv
// freq_div_multi: N-channel programmable divider producing a 50% square wave and a rising-edge tick per channel.
// Define FREQ_DIV_SYNC_EN to add sync_i, which restarts every channel in phase.
module freq_div_multi #(
  parameter int          N_CH     = 4,
  parameter int          CW       = 32,
  parameter int unsigned DEF_HALF = 25000000,
  localparam int         WCH      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            CP,
  input  logic            CR,
  input  logic [N_CH-1:0] en_i,
  input  logic            wr_en,
  input  logic [WCH-1:0]  wr_ch,
  input  logic [CW-1:0]   wr_data,
`ifdef FREQ_DIV_SYNC_EN
  input  logic            sync_i,
`endif
  output logic [N_CH-1:0] pend_o,
  output logic [N_CH-1:0] out_o,
  output logic [N_CH-1:0] tick_o
);

  logic [CW-1:0]   cnt_q  [N_CH];
  logic [CW-1:0]   cnt_d  [N_CH];
  logic [CW-1:0]   half_q [N_CH];
  logic [CW-1:0]   half_d [N_CH];
  logic [CW-1:0]   pval_q [N_CH];
  logic [CW-1:0]   pval_d [N_CH];
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] out_q, out_d;
  logic [N_CH-1:0] tick_q, tick_d;

  always_comb begin : next_state
    logic [CW-1:0] h;
    logic          wrap;
    logic          apply;
    pend_d = pend_q;
    out_d  = out_q;
    tick_d = '0;
    h      = '0;
    wrap   = 1'b0;
    apply  = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      cnt_d[c]  = cnt_q[c];
      half_d[c] = half_q[c];
      pval_d[c] = pval_q[c];
      h         = (half_q[c] == '0) ? CW'(1) : half_q[c];
      // >= rather than == keeps the counter bounded if a shorter period was applied while disabled
      wrap      = (cnt_q[c] >= h - CW'(1));
      apply     = 1'b0;
`ifdef FREQ_DIV_SYNC_EN
      if (sync_i) begin
        cnt_d[c] = '0;
        out_d[c] = 1'b0;
        apply    = pend_q[c];
      end else
`endif
      if (en_i[c]) begin
        if (wrap) begin
          cnt_d[c]  = '0;
          out_d[c]  = ~out_q[c];
          tick_d[c] = ~out_q[c];
          apply     = pend_q[c];
        end else begin
          cnt_d[c] = cnt_q[c] + CW'(1);
        end
      end else begin
        apply = pend_q[c];
      end
      if (apply) begin
        half_d[c] = pval_q[c];
        pend_d[c] = 1'b0;
      end
      // A write in the apply cycle lands after the apply, so it waits for the next wrap
      if (wr_en && (wr_ch == WCH'(c))) begin
        pval_d[c] = wr_data;
        pend_d[c] = 1'b1;
      end
    end
  end

  always_ff @(negedge CP or posedge CR) begin
    if (CR) begin
      for (int c = 0; c < N_CH; c++) begin
        cnt_q[c]  <= '0;
        half_q[c] <= CW'(DEF_HALF);
        pval_q[c] <= '0;
      end
      pend_q <= '0;
      out_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        cnt_q[c]  <= cnt_d[c];
        half_q[c] <= half_d[c];
        pval_q[c] <= pval_d[c];
      end
      pend_q <= pend_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign pend_o = pend_q;
  assign out_o  = out_q;
  assign tick_o = tick_q;

endmodule
